// File: rtl/riscv_pkg.sv
// Shared RISC-V types, write-back select codes and load funct3 encodings.
package riscv_pkg;

  localparam int XLEN      = 32;
  localparam int REG_COUNT = 32;
  localparam int REG_AW    = $clog2(REG_COUNT);

  typedef logic [XLEN-1:0]   xlen_t;
  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_RSVD = 2'd3
  } wb_sel_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_LOAD = 1'b1
  } wb_state_t;

  // Instruction fields held while a load is outstanding.
  typedef struct packed {
    logic      reg_write;
    reg_addr_t rd;
    wb_sel_t   wb_sel;
    logic [2:0] funct3;
    xlen_t     alu_result;
    xlen_t     pc_plus4;
  } wb_entry_t;

endpackage

// File: rtl/load_extender.sv
// Combinational load data alignment, sign/zero extension and misalignment detect.
module load_extender
  import riscv_pkg::*;
(
  input  xlen_t      word_i,
  input  logic [1:0] offset_i,
  input  logic [2:0] funct3_i,
  output xlen_t      data_o,
  output logic       misaligned_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = word_i[8*offset_i +: 8];
  assign w_half = offset_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    // NOTE: both outputs get a default first so no path through the case infers a latch.
    data_o       = word_i;
    misaligned_o = 1'b0;
    case (funct3_i)
      F3_LB:  data_o = {{24{w_byte[7]}}, w_byte};
      F3_LBU: data_o = {24'd0, w_byte};
      F3_LH: begin
        data_o       = {{16{w_half[15]}}, w_half};
        misaligned_o = offset_i[0];
      end
      F3_LHU: begin
        data_o       = {16'd0, w_half};
        misaligned_o = offset_i[0];
      end
      default: misaligned_o = (offset_i != 2'b00);  // LW and unknown encodings
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Write-back stage: accepts MEM-stage results, waits for load data, commits to the register file.
module writeback_unit
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mem_valid_i,
  output logic       mem_ready_o,
  input  logic       flush_i,
  input  logic       mem_reg_write_i,
  input  reg_addr_t  mem_rd_addr_i,
  input  wb_sel_t    mem_wb_sel_i,
  input  logic [2:0] mem_funct3_i,
  input  xlen_t      mem_alu_result_i,
  input  xlen_t      mem_pc_plus4_i,
  input  logic       dmem_rvalid_i,
  input  xlen_t      dmem_rdata_i,
  output logic       rf_we_o,
  output reg_addr_t  rf_rd_addr_o,
  output xlen_t      rf_rd_data_o,
  output logic       retire_o,
  output logic       misalign_o,
  output logic [63:0] instret_o
);

  wb_state_t   r_state;
  wb_entry_t   r_entry;
  logic [63:0] r_instret;
  xlen_t       w_load_data;
  logic        w_load_misaligned;

  load_extender u_load_extender (
    .word_i       (dmem_rdata_i),
    .offset_i     (r_entry.alu_result[1:0]),
    .funct3_i     (r_entry.funct3),
    .data_o       (w_load_data),
    .misaligned_o (w_load_misaligned)
  );

  assign mem_ready_o = (r_state == ST_IDLE);
  assign instret_o   = r_instret;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_entry      <= '0;
      r_instret    <= '0;
      rf_we_o      <= 1'b0;
      rf_rd_addr_o <= '0;
      rf_rd_data_o <= '0;
      retire_o     <= 1'b0;
      misalign_o   <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere here; every register samples pre-edge values.
      rf_we_o    <= 1'b0;
      retire_o   <= 1'b0;
      misalign_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (mem_valid_i && !flush_i) begin
            r_entry <= '{reg_write:  mem_reg_write_i,
                         rd:         mem_rd_addr_i,
                         wb_sel:     mem_wb_sel_i,
                         funct3:     mem_funct3_i,
                         alu_result: mem_alu_result_i,
                         pc_plus4:   mem_pc_plus4_i};
            if (mem_wb_sel_i == WB_LOAD) begin
              r_state <= ST_WAIT_LOAD;  // read data arriving this cycle is not ours
            end else begin
              rf_we_o      <= mem_reg_write_i && (mem_rd_addr_i != '0) &&
                              (mem_wb_sel_i != WB_RSVD);
              rf_rd_addr_o <= mem_rd_addr_i;
              rf_rd_data_o <= (mem_wb_sel_i == WB_PC4) ? mem_pc_plus4_i : mem_alu_result_i;
              retire_o     <= 1'b1;
              r_instret    <= r_instret + 64'd1;
            end
          end
        end
        ST_WAIT_LOAD: begin
          if (flush_i) begin
            r_state <= ST_IDLE;
          end else if (dmem_rvalid_i) begin
            r_state      <= ST_IDLE;
            rf_rd_addr_o <= r_entry.rd;
            rf_rd_data_o <= w_load_data;
            if (w_load_misaligned) begin
              misalign_o <= 1'b1;
            end else begin
              rf_we_o   <= r_entry.reg_write && (r_entry.rd != '0);
              retire_o  <= 1'b1;
              r_instret <= r_instret + 64'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed, table-driven bench for writeback_unit plus hand-written multi-cycle sequences.
module tb_writeback_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid_i, mem_ready_o, flush_i;
  logic        mem_reg_write_i;
  reg_addr_t   mem_rd_addr_i;
  wb_sel_t     mem_wb_sel_i;
  logic [2:0]  mem_funct3_i;
  xlen_t       mem_alu_result_i, mem_pc_plus4_i;
  logic        dmem_rvalid_i;
  xlen_t       dmem_rdata_i;
  logic        rf_we_o;
  reg_addr_t   rf_rd_addr_o;
  xlen_t       rf_rd_data_o;
  logic        retire_o, misalign_o;
  logic [63:0] instret_o;

  writeback_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_valid_i      (mem_valid_i),
    .mem_ready_o      (mem_ready_o),
    .flush_i          (flush_i),
    .mem_reg_write_i  (mem_reg_write_i),
    .mem_rd_addr_i    (mem_rd_addr_i),
    .mem_wb_sel_i     (mem_wb_sel_i),
    .mem_funct3_i     (mem_funct3_i),
    .mem_alu_result_i (mem_alu_result_i),
    .mem_pc_plus4_i   (mem_pc_plus4_i),
    .dmem_rvalid_i    (dmem_rvalid_i),
    .dmem_rdata_i     (dmem_rdata_i),
    .rf_we_o          (rf_we_o),
    .rf_rd_addr_o     (rf_rd_addr_o),
    .rf_rd_data_o     (rf_rd_data_o),
    .retire_o         (retire_o),
    .misalign_o       (misalign_o),
    .instret_o        (instret_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rw;
    reg_addr_t  rd;
    wb_sel_t    sel;
    logic [2:0] f3;
    xlen_t      alu;
    xlen_t      pc4;
    xlen_t      rdata;
    logic       e_we;
    logic       e_retire;
    logic       e_mis;
    logic       chk_data;
    xlen_t      e_data;
  } vec_t;

  int          n_pass = 0;
  int          n_total = 0;
  logic [63:0] exp_instret = 64'd0;
  vec_t        vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive_op(input logic rw, input reg_addr_t rd, input wb_sel_t sel,
                          input logic [2:0] f3, input xlen_t alu, input xlen_t pc4);
    mem_valid_i      = 1'b1;
    mem_reg_write_i  = rw;
    mem_rd_addr_i    = rd;
    mem_wb_sel_i     = sel;
    mem_funct3_i     = f3;
    mem_alu_result_i = alu;
    mem_pc_plus4_i   = pc4;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk);
    check($sformatf("v%0d ready_before", idx), {63'd0, mem_ready_o}, 64'd1);
    drive_op(v.rw, v.rd, v.sel, v.f3, v.alu, v.pc4);
    @(negedge clk);
    mem_valid_i = 1'b0;
    if (v.sel == WB_LOAD) begin
      check($sformatf("v%0d ready_wait", idx), {63'd0, mem_ready_o}, 64'd0);
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = v.rdata;
      @(negedge clk);
      dmem_rvalid_i = 1'b0;
    end
    if (v.e_retire) exp_instret++;
    check($sformatf("v%0d we", idx), {63'd0, rf_we_o}, {63'd0, v.e_we});
    check($sformatf("v%0d retire", idx), {63'd0, retire_o}, {63'd0, v.e_retire});
    check($sformatf("v%0d misalign", idx), {63'd0, misalign_o}, {63'd0, v.e_mis});
    check($sformatf("v%0d addr", idx), {59'd0, rf_rd_addr_o}, {59'd0, v.rd});
    if (v.chk_data) check($sformatf("v%0d data", idx), {32'd0, rf_rd_data_o}, {32'd0, v.e_data});
    check($sformatf("v%0d instret", idx), instret_o, exp_instret);
  endtask

  task automatic add(input logic rw, input reg_addr_t rd, input wb_sel_t sel, input logic [2:0] f3,
                     input xlen_t alu, input xlen_t pc4, input xlen_t rdata, input logic e_we,
                     input logic e_retire, input logic e_mis, input logic chk_data, input xlen_t e_data);
    vec_t v;
    v = '{rw, rd, sel, f3, alu, pc4, rdata, e_we, e_retire, e_mis, chk_data, e_data};
    vecs.push_back(v);
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    drive_op(1'b0, '0, WB_ALU, 3'b000, '0, '0);
    mem_valid_i = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst ready", {63'd0, mem_ready_o}, 64'd1);
    check("rst we", {63'd0, rf_we_o}, 64'd0);
    check("rst addr", {59'd0, rf_rd_addr_o}, 64'd0);
    check("rst data", {32'd0, rf_rd_data_o}, 64'd0);
    check("rst retire", {63'd0, retire_o | misalign_o}, 64'd0);
    check("rst instret", instret_o, 64'd0);
    rst_n = 1'b1;

    //   rw  rd  sel      f3      alu            pc4           rdata          we ret mis chk data
    add(1, 5,  WB_ALU,  3'b000, 32'h1234_5678, 32'h0,        32'h0,         1, 1, 0, 1, 32'h1234_5678);
    add(1, 1,  WB_PC4,  3'b000, 32'h0000_DEAD, 32'h0000_0104, 32'h0,        1, 1, 0, 1, 32'h0000_0104);
    add(1, 0,  WB_ALU,  3'b000, 32'h0000_0055, 32'h0,        32'h0,         0, 1, 0, 0, 32'h0);
    add(0, 7,  WB_ALU,  3'b000, 32'h0000_0077, 32'h0,        32'h0,         0, 1, 0, 1, 32'h0000_0077);
    add(1, 3,  WB_RSVD, 3'b000, 32'h0000_0033, 32'h0,        32'h0,         0, 1, 0, 0, 32'h0);
    add(1, 8,  WB_LOAD, F3_LBU, 32'h0000_1003, 32'h0,        32'h80FF_FF00, 1, 1, 0, 1, 32'h0000_0080);
    add(1, 9,  WB_LOAD, F3_LB,  32'h0000_1001, 32'h0,        32'h80FF_FF00, 1, 1, 0, 1, 32'hFFFF_FFFF);
    add(1, 10, WB_LOAD, F3_LBU, 32'h0000_1000, 32'h0,        32'h80FF_FF00, 1, 1, 0, 1, 32'h0000_0000);
    add(1, 11, WB_LOAD, F3_LHU, 32'h0000_1002, 32'h0,        32'hBEEF_0000, 1, 1, 0, 1, 32'h0000_BEEF);
    add(1, 12, WB_LOAD, F3_LH,  32'h0000_1002, 32'h0,        32'hBEEF_0000, 1, 1, 0, 1, 32'hFFFF_BEEF);
    add(1, 13, WB_LOAD, F3_LH,  32'h0000_1000, 32'h0,        32'h1234_7ABC, 1, 1, 0, 1, 32'h0000_7ABC);
    add(1, 14, WB_LOAD, F3_LW,  32'h0000_1000, 32'h0,        32'hCAFE_F00D, 1, 1, 0, 1, 32'hCAFE_F00D);
    add(1, 15, WB_LOAD, F3_LW,  32'h0000_1001, 32'h0,        32'hCAFE_F00D, 0, 0, 1, 0, 32'h0);
    add(1, 16, WB_LOAD, F3_LH,  32'h0000_1003, 32'h0,        32'hCAFE_F00D, 0, 0, 1, 0, 32'h0);
    add(1, 17, WB_LOAD, F3_LHU, 32'h0000_1001, 32'h0,        32'hCAFE_F00D, 0, 0, 1, 0, 32'h0);
    add(1, 18, WB_LOAD, 3'b011, 32'h0000_1004, 32'h0,        32'h1122_3344, 1, 1, 0, 1, 32'h1122_3344);
    add(1, 19, WB_LOAD, 3'b011, 32'h0000_1002, 32'h0,        32'h1122_3344, 0, 0, 1, 0, 32'h0);
    add(1, 0,  WB_LOAD, F3_LB,  32'h0000_1000, 32'h0,        32'h0000_0042, 0, 1, 0, 0, 32'h0);
    foreach (vecs[i]) apply_vec(vecs[i], i);

    // LB with data returned 3 cycles after accept; rvalid in the accept cycle is ignored
    @(negedge clk);
    drive_op(1'b1, 5'd20, WB_LOAD, F3_LB, 32'h0000_1003, 32'h0);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0000_0011;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      mem_valid_i = 1'b0;
      dmem_rvalid_i = (c == 3);
      dmem_rdata_i  = 32'h80FF_FF00;
      check($sformatf("lat c%0d ready", c), {63'd0, mem_ready_o}, 64'd0);
      check($sformatf("lat c%0d retire", c), {62'd0, retire_o, rf_we_o}, 64'd0);
    end
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    exp_instret++;
    check("lat commit we", {63'd0, rf_we_o}, 64'd1);
    check("lat commit data", {32'd0, rf_rd_data_o}, 64'h0000_0000_FFFF_FF80);
    check("lat commit ready", {63'd0, mem_ready_o}, 64'd1);
    check("lat instret", instret_o, exp_instret);

    // Back-to-back ALU accepts, one per cycle
    @(negedge clk);
    drive_op(1'b1, 5'd2, WB_ALU, 3'b000, 32'h0000_000A, 32'h0);
    @(negedge clk);
    drive_op(1'b1, 5'd3, WB_ALU, 3'b000, 32'h0000_000B, 32'h0);
    exp_instret++;
    check("b2b first addr", {59'd0, rf_rd_addr_o}, 64'd2);
    check("b2b first data", {32'd0, rf_rd_data_o}, 64'h0A);
    check("b2b ready", {63'd0, mem_ready_o}, 64'd1);
    @(negedge clk);
    mem_valid_i = 1'b0;
    exp_instret++;
    check("b2b second addr", {59'd0, rf_rd_addr_o}, 64'd3);
    check("b2b second data", {32'd0, rf_rd_data_o}, 64'h0B);
    check("b2b instret", instret_o, exp_instret);

    // Flush in IDLE blocks the new accept but not the commit already scheduled
    @(negedge clk);
    drive_op(1'b1, 5'd4, WB_ALU, 3'b000, 32'h0000_0444, 32'h0);
    @(negedge clk);
    drive_op(1'b1, 5'd6, WB_ALU, 3'b000, 32'h0000_0666, 32'h0);
    flush_i = 1'b1;
    exp_instret++;
    check("flush idle commit", {62'd0, retire_o, rf_we_o}, 64'd3);
    check("flush idle addr", {59'd0, rf_rd_addr_o}, 64'd4);
    @(negedge clk);
    mem_valid_i = 1'b0; flush_i = 1'b0;
    check("flush idle blocked", {62'd0, retire_o, rf_we_o}, 64'd0);
    check("flush idle instret", instret_o, exp_instret);

    // Flush while a load is pending, then late read data in IDLE
    @(negedge clk);
    drive_op(1'b1, 5'd21, WB_LOAD, F3_LW, 32'h0000_2000, 32'h0);
    @(negedge clk);
    mem_valid_i = 1'b0; flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("ldflush ready", {63'd0, mem_ready_o}, 64'd1);
    check("ldflush quiet", {61'd0, misalign_o, retire_o, rf_we_o}, 64'd0);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    check("ldflush late rvalid", {61'd0, misalign_o, retire_o, rf_we_o}, 64'd0);
    check("ldflush instret", instret_o, exp_instret);

    // Reset pulse while a load is pending
    @(negedge clk);
    drive_op(1'b1, 5'd22, WB_LOAD, F3_LW, 32'h0000_3000, 32'h0);
    @(negedge clk);
    mem_valid_i = 1'b0; rst_n = 1'b0;
    exp_instret = 64'd0;
    #1;
    check("ldrst ready", {63'd0, mem_ready_o}, 64'd1);
    check("ldrst instret", instret_o, exp_instret);
    @(negedge clk);
    rst_n = 1'b1;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1357_9BDF;
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    check("ldrst late rvalid", {61'd0, misalign_o, retire_o, rf_we_o}, 64'd0);
    check("ldrst ready after", {63'd0, mem_ready_o}, 64'd1);

    // Retired-instruction counter wrap
    @(negedge clk);
    force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    release dut.r_instret;
    check("wrap preset", instret_o, 64'hFFFF_FFFF_FFFF_FFFF);
    drive_op(1'b1, 5'd23, WB_ALU, 3'b000, 32'h0000_0023, 32'h0);
    @(negedge clk);
    mem_valid_i = 1'b0;
    check("wrap retire", {63'd0, retire_o}, 64'd1);
    check("wrap instret", instret_o, 64'd0);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have: mem_valid_i  in  1  MEM stage presents an instruction; mem_ready_o  out  1  unit can accept; flush_i  in  1  kill accept/pending load.
REQ-003 SHALL have: mem_reg_write_i  in  1; mem_rd_addr_i  in  reg_addr_t (5); mem_wb_sel_i  in  wb_sel_t (2: ALU=0, LOAD=1, PC4=2, 3 reserved); mem_funct3_i  in  3  load type.
REQ-004 SHALL have: mem_alu_result_i  in  xlen_t (32)  result/load address; mem_pc_plus4_i  in  xlen_t.
REQ-005 SHALL have: dmem_rvalid_i  in  1  load data return; dmem_rdata_i  in  xlen_t  raw aligned word.
REQ-006 SHALL have: rf_we_o  out  1; rf_rd_addr_o  out  reg_addr_t; rf_rd_data_o  out  xlen_t (register-file write port).
REQ-007 SHALL have: retire_o  out  1  commit pulse; misalign_o  out  1  misaligned-load pulse; instret_o  out  64  retired count.

Function
REQ-008 SHALL implement FSM states IDLE, WAIT_LOAD; mem_ready_o = (state==IDLE).
REQ-009 Accept SHALL occur when mem_valid_i & mem_ready_o & !flush_i; fields captured in entry register.
REQ-010 Accept with wb_sel ALU/PC4 SHALL commit the next cycle; state stays IDLE (back-to-back accepts, one per cycle).
REQ-011 Accept with wb_sel LOAD SHALL move to WAIT_LOAD; if dmem_rvalid_i is already high in the accept cycle it is ignored (data belongs to the next cycle onward).
REQ-012 In WAIT_LOAD, dmem_rvalid_i & !flush_i SHALL commit the next cycle and return to IDLE; flush_i in WAIT_LOAD SHALL return to IDLE with no write, retire, or misalign.
REQ-013 Commit cycle: rf_we_o = reg_write & (rd!=0); rf_rd_addr_o/rf_rd_data_o valid; retire_o=1; all outputs registered, one-cycle pulses.
REQ-014 rf_rd_data_o SHALL be alu_result (ALU), pc_plus4 (PC4), extracted load (LOAD); wb_sel=3 SHALL commit with rf_we_o=0.
REQ-015 Load extract, off=alu_result[1:0]: LB(000)/LBU(100) byte off, sign/zero-extend; LH(001)/LHU(101) halfword off[1], sign/zero-extend; LW(010) full word; other funct3 treated as LW.
REQ-016 Misaligned (LH/LHU off[0]=1; LW off!=0) SHALL pulse misalign_o at commit, rf_we_o=0, retire_o=0, instret unchanged.
REQ-017 instret_o SHALL increment by 1 per retire_o, including rd=0 or reg_write=0; wraps 2^64-1 -> 0.
REQ-018 rf_we_o SHALL never assert with rf_rd_addr_o=0.
REQ-019 flush_i in IDLE SHALL block accept only; a commit already scheduled for that cycle still occurs.

Reset
REQ-020 On rst_n low: state IDLE, rf_we_o=0, rf_rd_addr_o=0, rf_rd_data_o=0, retire_o=0, misalign_o=0, instret_o=0, entry cleared; mem_ready_o=1 during/after reset.
REQ-021 Reset mid-WAIT_LOAD SHALL discard the pending load; a subsequent dmem_rvalid_i in IDLE SHALL be ignored.

Structure
REQ-022 xlen_t, reg_addr_t, REG_COUNT, wb_sel_t, funct3 load encodings SHALL live in riscv_pkg.
REQ-023 Load alignment/extension SHALL be one combinational sub-module load_extender (inputs word, offset, funct3; outputs data, misaligned).

Verification
REQ-024 ALU accept rd=5, result 0x1234_5678 -> next cycle rf_we_o=1, addr 5, data 0x1234_5678, retire_o=1, instret 0->1.
REQ-025 LB, addr 0x1003, rdata 0x80FF_FF00 returned 3 cycles later -> mem_ready_o=0 for 3 cycles, commit data 0xFFFF_FF80.
REQ-026 LHU addr 0x1002, rdata 0xBEEF_0000 -> data 0x0000_BEEF; LW addr 0x1001 -> misalign_o=1, rf_we_o=0, instret unchanged.
REQ-027 ALU accept rd=0, reg_write=1 -> rf_we_o=0, retire_o=1, instret increments.
REQ-028 Load pending, flush_i then dmem_rvalid_i -> no write/retire, mem_ready_o=1 after flush; same with rst_n pulse instead.
REQ-029 instret preset to 0xFFFF_FFFF_FFFF_FFFF via forced back-door, one commit -> instret_o=0.
